// File: rtl/id_ex_if.sv
// Decode/execute stage bus: decode fields in, MEM/WB forwarding sources in, execute fields out.
// The stage itself uses the slave modport; the surrounding pipeline (or bench) uses master.
interface id_ex_if;
  logic        ValidD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
  logic [31:0] ExtImmD;
  logic [2:0]  ALUFuncD;
  logic        OpBSrcD;
  logic        RegWriteD;
  logic        MemReadD;
  logic        MemWriteD;
  logic        FlushE;
  logic [31:0] ALUResultM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        ValidM;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic        ValidW;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [31:0] ExtImmE;
  logic [2:0]  ALUFuncE;
  logic        OpBSrcE;
  logic [4:0]  RdE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic        RegWriteE;
  logic        MemReadE;
  logic        MemWriteE;
  logic        ValidE;
  logic        StallD;

  modport slave (
    input  ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD, ExtImmD, ALUFuncD, OpBSrcD,
    input  RegWriteD, MemReadD, MemWriteD, FlushE,
    input  ALUResultM, RdM, RegWriteM, ValidM, ResultW, RdW, RegWriteW, ValidW,
    output OpA, OpB, ExtImmE, ALUFuncE, OpBSrcE, RdE, Rs1E, Rs2E,
    output RegWriteE, MemReadE, MemWriteE, ValidE, StallD
  );

  modport master (
    output ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD, ExtImmD, ALUFuncD, OpBSrcD,
    output RegWriteD, MemReadD, MemWriteD, FlushE,
    output ALUResultM, RdM, RegWriteM, ValidM, ResultW, RdW, RegWriteW, ValidW,
    input  OpA, OpB, ExtImmE, ALUFuncE, OpBSrcE, RdE, Rs1E, Rs2E,
    input  RegWriteE, MemReadE, MemWriteE, ValidE, StallD
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall detection and flush.
// A flush or load-use hazard turns the entering instruction into an all-zero bubble.
module id_ex_stage (
  input logic     clk,
  input logic     reset,
  id_ex_if.slave  io
);

  logic        valid_q,     valid_d;
  logic [31:0] rd1_q,       rd1_d;
  logic [31:0] rd2_q,       rd2_d;
  logic [31:0] imm_q,       imm_d;
  logic [2:0]  func_q,      func_d;
  logic        opb_src_q,   opb_src_d;
  logic [4:0]  rd_q,        rd_d;
  logic [4:0]  rs1_q,       rs1_d;
  logic [4:0]  rs2_q,       rs2_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q,  mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic stall;
  logic bubble;

  always_comb begin
    stall = valid_q & mem_read_q & (rd_q != 5'd0) & io.ValidD &
            ((rd_q == io.Rs1D) | (rd_q == io.Rs2D)) & ~io.FlushE;
    bubble = io.FlushE | stall;
  end

  always_comb begin
    valid_d     = 1'b0;
    rd1_d       = '0;
    rd2_d       = '0;
    imm_d       = '0;
    func_d      = 3'b000;
    opb_src_d   = 1'b0;
    rd_d        = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    if (!bubble) begin
      valid_d     = io.ValidD;
      rd1_d       = io.RD1D;
      rd2_d       = io.RD2D;
      imm_d       = io.ExtImmD;
      func_d      = io.ALUFuncD;
      opb_src_d   = io.OpBSrcD;
      rd_d        = io.RdD;
      rs1_d       = io.Rs1D;
      rs2_d       = io.Rs2D;
      reg_write_d = io.RegWriteD;
      mem_read_d  = io.MemReadD;
      mem_write_d = io.MemWriteD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      func_q      <= 3'b000;
      opb_src_q   <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      func_q      <= func_d;
      opb_src_q   <= opb_src_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // MEM beats WB; x0 is never forwarded. Registered operands stay untouched.
  logic m_en, w_en;
  always_comb begin
    m_en = io.RegWriteM & io.ValidM & (io.RdM != 5'd0);
    w_en = io.RegWriteW & io.ValidW & (io.RdW != 5'd0);

    if (m_en && (io.RdM == rs1_q))      io.OpA = io.ALUResultM;
    else if (w_en && (io.RdW == rs1_q)) io.OpA = io.ResultW;
    else                                io.OpA = rd1_q;

    if (m_en && (io.RdM == rs2_q))      io.OpB = io.ALUResultM;
    else if (w_en && (io.RdW == rs2_q)) io.OpB = io.ResultW;
    else                                io.OpB = rd2_q;
  end

  assign io.ExtImmE   = imm_q;
  assign io.ALUFuncE  = func_q;
  assign io.OpBSrcE   = opb_src_q;
  assign io.RdE       = rd_q;
  assign io.Rs1E      = rs1_q;
  assign io.Rs2E      = rs2_q;
  assign io.RegWriteE = reg_write_q;
  assign io.MemReadE  = mem_read_q;
  assign io.MemWriteE = mem_write_q;
  assign io.ValidE    = valid_q;
  assign io.StallD    = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, x0 exclusion, load-use, flush, reset.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ValidD = 0; bus.RD1D = 0; bus.RD2D = 0; bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0;
    bus.ExtImmD = 0; bus.ALUFuncD = 0; bus.OpBSrcD = 0; bus.RegWriteD = 0;
    bus.MemReadD = 0; bus.MemWriteD = 0; bus.FlushE = 0;
    bus.ALUResultM = 0; bus.RdM = 0; bus.RegWriteM = 0; bus.ValidM = 0;
    bus.ResultW = 0; bus.RdW = 0; bus.RegWriteW = 0; bus.ValidW = 0;
  endtask

  task automatic drive_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic load);
    bus.ValidD = 1; bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RdD = rd;
    bus.RD1D = v1; bus.RD2D = v2; bus.RegWriteD = 1; bus.MemReadD = load;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_valid", 32'(bus.ValidE), 0);
    chk("reset_stall", 32'(bus.StallD), 0);
    chk("reset_opa", bus.OpA, 0);
    chk("reset_opb", bus.OpB, 0);
    chk("reset_func", 32'(bus.ALUFuncE), 0);

    // Plain capture
    drive_d(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
    bus.ALUFuncD = 3'b001; bus.ExtImmD = 32'h10; bus.OpBSrcD = 1;
    step();
    chk("cap_opa", bus.OpA, 32'd5);
    chk("cap_opb", bus.OpB, 32'd7);
    chk("cap_func", 32'(bus.ALUFuncE), 32'd1);
    chk("cap_rd", 32'(bus.RdE), 32'd3);
    chk("cap_valid", 32'(bus.ValidE), 32'd1);
    chk("cap_imm", bus.ExtImmE, 32'h10);
    chk("cap_opbsrc", 32'(bus.OpBSrcE), 32'd1);
    chk("cap_rs1", 32'(bus.Rs1E), 32'd1);

    // MEM vs WB priority
    drive_d(5'd4, 5'd0, 5'd8, 32'hAA, 32'hBB, 1'b0);
    bus.ALUFuncD = 3'b000; bus.OpBSrcD = 0; bus.ExtImmD = 0;
    step();
    bus.RdM = 5'd4; bus.ALUResultM = 32'h11; bus.RegWriteM = 1; bus.ValidM = 1;
    bus.RdW = 5'd4; bus.ResultW = 32'h22; bus.RegWriteW = 1; bus.ValidW = 1;
    #1;
    chk("fwd_mem_prio", bus.OpA, 32'h11);
    chk("fwd_opb_nomatch", bus.OpB, 32'hBB);
    bus.RdM = 5'd0;
    #1;
    chk("fwd_wb", bus.OpA, 32'h22);
    bus.RdM = 5'd4; bus.ValidM = 0;
    #1;
    chk("fwd_m_invalid", bus.OpA, 32'h22);
    bus.RegWriteW = 0;
    #1;
    chk("fwd_none", bus.OpA, 32'hAA);

    // x0 exclusion on OpB
    clear_inputs();
    drive_d(5'd1, 5'd0, 5'd9, 32'h1, 32'h0, 1'b0);
    step();
    bus.RdM = 5'd0; bus.RegWriteM = 1; bus.ValidM = 1; bus.ALUResultM = 32'hFFFF_FFFF;
    bus.RdW = 5'd0; bus.RegWriteW = 1; bus.ValidW = 1; bus.ResultW = 32'h5555_5555;
    #1;
    chk("x0_opb_zero", bus.OpB, 32'h0);
    drive_d(5'd1, 5'd0, 5'd9, 32'h1, 32'h33, 1'b0);
    step();
    chk("x0_opb_reg", bus.OpB, 32'h33);

    // Load-use: load x6, then consumer of x6
    clear_inputs();
    drive_d(5'd2, 5'd3, 5'd6, 32'h0, 32'h0, 1'b1);
    step();
    chk("ld_memread", 32'(bus.MemReadE), 32'd1);
    drive_d(5'd6, 5'd9, 5'd7, 32'h55, 32'h0, 1'b0);
    #1;
    chk("lu_stall", 32'(bus.StallD), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(bus.ValidE), 32'd0);
    chk("lu_bubble_regw", 32'(bus.RegWriteE), 32'd0);
    chk("lu_stall_drop", 32'(bus.StallD), 32'd0);
    step();
    chk("lu_cons_valid", 32'(bus.ValidE), 32'd1);
    chk("lu_cons_rs1", 32'(bus.Rs1E), 32'd6);
    bus.RdW = 5'd6; bus.ResultW = 32'h99; bus.RegWriteW = 1; bus.ValidW = 1;
    #1;
    chk("lu_wb_fwd", bus.OpA, 32'h99);

    // Load then independent instruction, and load into x0: no stall
    clear_inputs();
    drive_d(5'd2, 5'd3, 5'd5, 32'h0, 32'h0, 1'b1);
    step();
    drive_d(5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 1'b0);
    #1;
    chk("indep_nostall", 32'(bus.StallD), 32'd0);
    drive_d(5'd2, 5'd3, 5'd0, 32'h0, 32'h0, 1'b1);
    step();
    drive_d(5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 1'b0);
    #1;
    chk("x0_load_nostall", 32'(bus.StallD), 32'd0);

    // Flush beats stall
    drive_d(5'd2, 5'd3, 5'd6, 32'h0, 32'h0, 1'b1);
    step();
    drive_d(5'd1, 5'd6, 5'd7, 32'h0, 32'h0, 1'b0);
    #1;
    chk("pre_flush_stall", 32'(bus.StallD), 32'd1);
    bus.FlushE = 1;
    #1;
    chk("flush_stall", 32'(bus.StallD), 32'd0);
    step();
    chk("flush_valid", 32'(bus.ValidE), 32'd0);
    chk("flush_regw", 32'(bus.RegWriteE), 32'd0);
    chk("flush_rs2", 32'(bus.Rs2E), 32'd0);

    // Asynchronous reset mid-cycle
    clear_inputs();
    drive_d(5'd2, 5'd3, 5'd6, 32'h44, 32'h66, 1'b1);
    bus.ALUFuncD = 3'b101;
    step();
    chk("pre_rst_valid", 32'(bus.ValidE), 32'd1);
    drive_d(5'd6, 5'd0, 5'd7, 32'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.ValidE), 32'd0);
    chk("rst_rd", 32'(bus.RdE), 32'd0);
    chk("rst_func", 32'(bus.ALUFuncE), 32'd0);
    chk("rst_opa", bus.OpA, 32'd0);
    chk("rst_stall", 32'(bus.StallD), 32'd0);
    chk("rst_memread", 32'(bus.MemReadE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage: registers decoded operands and control on each clock edge and presents them to the execute-stage ALU as OpA, OpB, ExtImmE, ALUFuncE and OpBSrcE. It resolves read-after-write hazards by forwarding from the MEM and WB stages. It detects load-use hazards, asserting a decode stall and inserting one bubble. It accepts a flush from branch resolution and turns the entering instruction into a bubble.

## Interface

Parameters: none. Data width is fixed at 32 bits; register index width is fixed at 5 bits.

Ports:

- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ValidD  in  1  decode holds a real instruction.
- RD1D, RD2D  in  32  register-file read data for rs1 and rs2.
- Rs1D, Rs2D, RdD  in  5  source and destination register indices.
- ExtImmD  in  32  sign-extended immediate.
- ALUFuncD  in  3  ALU function code.
- OpBSrcD  in  1  1 selects the immediate as ALU operand B.
- RegWriteD, MemReadD, MemWriteD  in  1  instruction control bits.
- FlushE  in  1  from branch resolution; kills the instruction entering E.
- ALUResultM  in  32  MEM-stage ALU result.
- RdM  in  5  MEM-stage destination index.
- RegWriteM, ValidM  in  1  MEM-stage write-enable and valid.
- ResultW  in  32  WB-stage write-back value.
- RdW  in  5  WB-stage destination index.
- RegWriteW, ValidW  in  1  WB-stage write-enable and valid.
- OpA, OpB  out  32  forwarded operands to the ALU.
- ExtImmE  out  32  registered immediate.
- ALUFuncE  out  3  registered function code.
- OpBSrcE  out  1  registered operand-B select.
- RdE, Rs1E, Rs2E  out  5  registered indices.
- RegWriteE, MemReadE, MemWriteE, ValidE  out  1  registered control and valid.
- StallD  out  1  holds fetch and decode for this cycle.

## Operation

- E register update priority at each edge: reset > FlushE > load-use bubble > normal capture.
- Normal capture: all D-suffixed fields are copied into their E registers. ValidE takes ValidD.
- Bubble (FlushE=1, or StallD=1 with FlushE=0):
  - ValidE, RegWriteE, MemReadE and MemWriteE load 0.
  - All data and index fields load 0. ALUFuncE loads 3'b000.
- Load-use hazard: StallD = ValidE & MemReadE & (RdE != 0) & ValidD & (RdE == Rs1D | RdE == Rs2D) & ~FlushE.
  - StallD is purely combinational.
  - Upstream holds D while StallD is high. This stage inserts exactly one bubble.
  - The load then sits in W when the consumer reaches E, so the value arrives through WB forwarding.
- Forwarding for OpA (OpB is identical, using Rs2E and the registered rs2 data):
  - If RegWriteM & ValidM & (RdM != 0) & (RdM == Rs1E): ALUResultM.
  - Else if RegWriteW & ValidW & (RdW != 0) & (RdW == Rs1E): ResultW.
  - Else: the registered RD1.
  - MEM takes priority over WB. x0 is never forwarded.
- OpB is always the forwarded rs2 value. Immediate selection stays inside the ALU via OpBSrcE.
- Forwarding applies only to values leaving the stage. Registered RD1/RD2 are never overwritten by forwarded data.

## Timing

- Latency: one cycle from D inputs to E outputs.
- StallD, OpA and OpB are combinational from registered state and the same-cycle M/W inputs.
- Reset: every registered output is 0, including ValidE, ALUFuncE=000 and all indices. StallD=0. OpA and OpB equal 0 unless M/W forwarding matches index 0, which is excluded.
- Reset asserted mid-operation: the stage clears immediately, without waiting for a clock edge.
- FlushE and a hazard together: the flush wins, StallD=0, and one bubble is inserted.
- The back-to-back load-use stall lasts exactly one cycle. After the bubble, MemReadE=0, so StallD drops.
- A load followed by an independent instruction produces no stall. A load into x0 never stalls.

## Test plan

- Reset: assert reset mid-stream with ValidE=1 → on the next evaluation, all E outputs are 0, ValidE=0 and StallD=0, with no clock edge needed.
- Plain capture: ValidD=1, RD1D=5, RD2D=7, ALUFuncD=001, RdD=3 → after one edge, OpA=5, OpB=7, ALUFuncE=001, RdE=3, ValidE=1.
- MEM priority: Rs1E=4, RdM=4 with ALUResultM=0x11, RdW=4 with ResultW=0x22, both write-enabled and valid → OpA=0x11. Repeat with RdM=0 → OpA=0x22.
- x0 exclusion: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFFFF_FFFF → OpB equals the registered RD2, which is 0.
- Load-use: E holds a load with RdE=6 and D has Rs1D=6 → StallD=1 this cycle; the next edge gives ValidE=0 and StallD=0. When the consumer enters E with RdW=6 and ResultW=0x99, OpA=0x99.
- Flush vs stall: load-use condition present and FlushE=1 in the same cycle → StallD=0, and the next edge gives ValidE=0 and RegWriteE=0.
